// File: rtl/sh_mem_core_port_pkg.sv
// Shared constants and types for the core-side shared-memory port:
// bus widths, mem_enable encodings, port FSM states and the queued command record.
package sh_mem_core_port_pkg;

  localparam int unsigned ADDR_SIZE    = 12;
  localparam int unsigned REG_SIZE     = 8;
  localparam int unsigned BANK_ID_SIZE = 4;

  localparam logic [1:0] MEM_EN_IDLE = 2'b00;
  localparam logic [1:0] MEM_EN_RD   = 2'b01;
  localparam logic [1:0] MEM_EN_WR   = 2'b10;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'b00,
    PORT_ISSUE = 2'b01,
    PORT_DRAIN = 2'b10
  } port_state_e;

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [REG_SIZE-1:0]  wdata;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  function automatic logic [1:0] mem_en_of(input cmd_t c);
    return c.we ? MEM_EN_WR : MEM_EN_RD;
  endfunction

endpackage

// File: rtl/sh_mem_core_port_if.sv
// One core's slice of the shared-memory bus: the core port is the master,
// the bank arbiter is the slave.
interface sh_mem_core_port_if;

  logic [1:0]                               mem_enable;
  logic [sh_mem_core_port_pkg::ADDR_SIZE-1:0] mem_addr;
  logic [sh_mem_core_port_pkg::REG_SIZE-1:0]  mem_wr_data;
  logic [sh_mem_core_port_pkg::REG_SIZE-1:0]  mem_rd_data;
  logic                                     mem_ready;

  modport master (
    output mem_enable, mem_addr, mem_wr_data,
    input  mem_rd_data, mem_ready
  );

  modport slave (
    input  mem_enable, mem_addr, mem_wr_data,
    output mem_rd_data, mem_ready
  );

endinterface

// File: rtl/sh_mem_core_port_cmd_fifo.sv
// First-word-fall-through command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. The count is one bit wider than the pointers.
module sh_mem_core_port_cmd_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  cnt_t             cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == cnt_t'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sh_mem_core_port.sv
// Core-side initiator: queues LSU commands and issues them one at a time to
// the shared-memory arbiter, returning load data and flagging starvation.
module sh_mem_core_port
  import sh_mem_core_port_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [REG_SIZE-1:0]  req_wdata,
  output logic                 rsp_valid,
  output logic [REG_SIZE-1:0]  rsp_rdata,
  output logic                 busy,
  output logic                 timeout_err,
  sh_mem_core_port_if.master   mem
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  TMO   = 8'(TIMEOUT_CYCLES);

  port_state_e      state;
  cmd_t             req_cmd, head;
  logic             full, empty, push, pop, issue;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       wait_cnt;

  assign req_cmd   = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign issue     = (state == PORT_ISSUE);
  assign pop       = issue && mem.mem_ready;
  assign busy      = (state != PORT_IDLE) || !empty;

  sh_mem_core_port_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (req_cmd),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head)
  );

  // Bus outputs follow the FIFO head directly so they are stable for the whole ISSUE phase.
  always_comb begin
    mem.mem_enable  = MEM_EN_IDLE;
    mem.mem_addr    = '0;
    mem.mem_wr_data = '0;
    if (issue) begin
      mem.mem_enable = mem_en_of(head);
      mem.mem_addr   = head.addr;
      if (head.we) mem.mem_wr_data = head.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= PORT_IDLE;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        PORT_IDLE: begin
          if (!empty) begin
            state    <= PORT_ISSUE;
            wait_cnt <= '0;
          end
        end
        PORT_ISSUE: begin
          if (mem.mem_ready) begin
            wait_cnt <= '0;
            if (head.we) begin
              // A same-cycle push also leaves work queued, so stay in ISSUE.
              state <= ((fifo_count > CNT_W'(1)) || push) ? PORT_ISSUE : PORT_IDLE;
            end else begin
              rsp_rdata <= mem.mem_rd_data;
              rsp_valid <= 1'b1;
              state     <= PORT_DRAIN;
            end
          end else if (wait_cnt != TMO) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == TMO) timeout_err <= 1'b1;
          end
        end
        PORT_DRAIN: begin
          wait_cnt <= '0;
          state    <= empty ? PORT_IDLE : PORT_ISSUE;
        end
        default: state <= PORT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sh_mem_core_port.sv
// Directed bench for sh_mem_core_port: a cycle-by-cycle vector table for the
// single-write and mixed back-to-back cases, plus hand-written multi-cycle sequences.
module tb_sh_mem_core_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int p0;

  always #5 clk = ~clk;

  sh_mem_core_port_if mem_bus();

  sh_mem_core_port #(
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .timeout_err (timeout_err),
    .mem         (mem_bus)
  );

  always @(posedge clk) if (rsp_valid === 1'b1) pulses++;

  typedef struct {
    logic        valid;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wd;
    logic        ready;
    logic [7:0]  rd;
    logic        e_rr;
    logic [1:0]  e_en;
    logic [11:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_rv;
    logic [7:0]  e_rdata;
    logic        e_busy;
    logic        e_terr;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rr, input logic [1:0] e_en,
                           input logic [11:0] e_addr, input logic [7:0] e_wd, input logic e_rv,
                           input logic [7:0] e_rdata, input logic e_busy, input logic e_terr);
    check({tag, ".req_ready"},   32'(req_ready),            32'(e_rr));
    check({tag, ".mem_enable"},  32'(mem_bus.mem_enable),   32'(e_en));
    check({tag, ".mem_addr"},    32'(mem_bus.mem_addr),     32'(e_addr));
    check({tag, ".mem_wr_data"}, 32'(mem_bus.mem_wr_data),  32'(e_wd));
    check({tag, ".rsp_valid"},   32'(rsp_valid),            32'(e_rv));
    check({tag, ".rsp_rdata"},   32'(rsp_rdata),            32'(e_rdata));
    check({tag, ".busy"},        32'(busy),                 32'(e_busy));
    check({tag, ".timeout_err"}, 32'(timeout_err),          32'(e_terr));
  endtask

  task automatic drive(input logic v, input logic we, input logic [11:0] a, input logic [7:0] wd,
                       input logic rdy, input logic [7:0] rd);
    req_valid           = v;
    req_we              = we;
    req_addr            = a;
    req_wdata           = wd;
    mem_bus.mem_ready   = rdy;
    mem_bus.mem_rd_data = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          in: v     we    addr     wd     rdy   rd      exp: rr   en     addr     wd     rv    rdata  busy  terr
    vec[0]  = '{1'b1, 1'b1, 12'h3A5, 8'h5C, 1'b0, 8'h00, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h00, 1'b1, 2'b10, 12'h3A5, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h66, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 12'h111, 8'h11, 1'b0, 8'h00, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 12'h222, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 12'h333, 8'h33, 1'b1, 8'h00, 1'b0, 2'b10, 12'h111, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 12'h333, 8'h33, 1'b1, 8'h9C, 1'b1, 2'b01, 12'h222, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h55, 1'b1, 2'b00, 12'h000, 8'h00, 1'b1, 8'h9C, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h00, 1'b1, 2'b10, 12'h333, 8'h33, 1'b0, 8'h9C, 1'b1, 1'b0};
    vec[11] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h9C, 1'b0, 1'b0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].valid, vec[i].we, vec[i].addr, vec[i].wd, vec[i].ready, vec[i].rd);
      check_all($sformatf("vec%0d", i), vec[i].e_rr, vec[i].e_en, vec[i].e_addr, vec[i].e_wd,
                vec[i].e_rv, vec[i].e_rdata, vec[i].e_busy, vec[i].e_terr);
      tick();
    end

    // Read with three contended cycles, then a stale ready during DRAIN.
    drive(1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 8'h00);
    check_all("rd_accept", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h9C, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    check_all("rd_idle", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h9C, 1'b1, 1'b0);
    tick();
    p0 = pulses;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      check_all($sformatf("rd_wait%0d", c), 1'b1, 2'b01, 12'h010, 8'h00, 1'b0, 8'h9C, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'hA7);
    check_all("rd_grant", 1'b1, 2'b01, 12'h010, 8'h00, 1'b0, 8'h9C, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h3C);
    check_all("rd_drain", 1'b1, 2'b00, 12'h000, 8'h00, 1'b1, 8'hA7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    check_all("rd_done", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'hA7, 1'b0, 1'b0);
    tick();
    check("rd_pulse_count", 32'(pulses - p0), 32'd1);

    // Full FIFO: third write blocked until the first completes, order preserved.
    drive(1'b1, 1'b1, 12'h101, 8'hA1, 1'b0, 8'h00);
    check_all("ff_a", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'hA7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 12'h102, 8'hB2, 1'b0, 8'h00);
    check_all("ff_b", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'hA7, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 12'h103, 8'hC3, 1'b0, 8'h00);
      check_all($sformatf("ff_block%0d", c), 1'b0, 2'b10, 12'h101, 8'hA1, 1'b0, 8'hA7, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 12'h103, 8'hC3, 1'b1, 8'h00);
    check_all("ff_grant_a", 1'b0, 2'b10, 12'h101, 8'hA1, 1'b0, 8'hA7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 12'h103, 8'hC3, 1'b0, 8'h00);
    check_all("ff_accept_c", 1'b1, 2'b10, 12'h102, 8'hB2, 1'b0, 8'hA7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h00);
    check_all("ff_grant_b", 1'b0, 2'b10, 12'h102, 8'hB2, 1'b0, 8'hA7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h00);
    check_all("ff_grant_c", 1'b1, 2'b10, 12'h103, 8'hC3, 1'b0, 8'hA7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    check_all("ff_idle", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'hA7, 1'b0, 1'b0);
    tick();

    // Starvation: 260 stalled ISSUE cycles; the flag rises after the 255th.
    drive(1'b1, 1'b1, 12'h0FF, 8'h77, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    tick();
    for (int n = 1; n <= 260; n++) begin
      drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      if (n == 1 || n == 255 || n == 256 || n == 260)
        check_all($sformatf("starve_c%0d", n), 1'b1, 2'b10, 12'h0FF, 8'h77, 1'b0, 8'hA7, 1'b1,
                  (n > 255) ? 1'b1 : 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h00);
    check_all("starve_grant", 1'b1, 2'b10, 12'h0FF, 8'h77, 1'b0, 8'hA7, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    check_all("starve_done", 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'hA7, 1'b0, 1'b1);
    tick();

    // Reset while a read is in ISSUE: request abandoned, no response.
    drive(1'b1, 1'b0, 12'h456, 8'h00, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    tick();
    check_all("rst_issue", 1'b1, 2'b01, 12'h456, 8'h00, 1'b0, 8'hA7, 1'b1, 1'b1);
    tick();
    p0 = pulses;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'hEE);
      check_all($sformatf("rst_after%0d", c), 1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    check("rst_no_rsp", 32'(pulses - p0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
